// File: rtl/assoc_store_pkg.sv
// ---------------------------------------------------------------------------
// assoc_store_pkg
// Shared types for the associative key/value store:
//   op_e         - request opcode (READ / WRITE / DELETE / CLEAR)
//   state_e      - response-register FSM state
//   rsp_t        - registered response payload (rdata, hit, evict)
//   countWidth() - width needed to hold an entry count of 0..depth
// ---------------------------------------------------------------------------
package assoc_store_pkg;

    // Request opcodes as they appear on the 2-bit op field
    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    // Response register is either empty or holding one response
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Data width carried by the response struct; the top narrows or widens
    // to its own DATA_W with size casts, so the default build is exact
    localparam int PKG_DATA_W = 64;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] rdata;
        logic                  hit;
        logic                  evict;
    } rsp_t;

    // A count must reach depth itself, hence depth+1 states
    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/assoc_store_find.sv
// ---------------------------------------------------------------------------
// assoc_store_find
// Combinational lookup over all entries: compares the request key against
// every valid key and finds the lowest-index free slot.
// Ports:
//   i_valid   [DEPTH]          per-entry valid bits
//   i_keys    [DEPTH*ADDR_W]   entry keys, entry i at bits i*ADDR_W +: ADDR_W
//   i_addr    [ADDR_W]         key being looked up
//   o_hit / o_hitIdx           a valid entry holds i_addr, and which one
//   o_free / o_freeIdx         some entry is invalid, and the lowest such
// ---------------------------------------------------------------------------
module assoc_store_find #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]        i_valid,
    input  logic [DEPTH*ADDR_W-1:0] i_keys,
    input  logic [ADDR_W-1:0]       i_addr,
    output logic                    o_hit,
    output logic [IDX_W-1:0]        o_hitIdx,
    output logic                    o_free,
    output logic [IDX_W-1:0]        o_freeIdx
);

    logic [DEPTH-1:0] w_match;

    // Full-width key compare against every entry, gated by its valid bit
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = i_valid[i] && (i_keys[i*ADDR_W +: ADDR_W] == i_addr);
        end
    end

    // Priority encoders: scanning downwards lets the lowest index win.
    // Keys are unique, so at most one match exists anyway; for free slots
    // the lowest index is the one that gets allocated.
    always_comb begin
        o_hit     = 1'b0;
        o_hitIdx  = '0;
        o_free    = 1'b0;
        o_freeIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = 1'b1;
                o_hitIdx = IDX_W'(i);
            end
            if (!i_valid[i]) begin
                o_free    = 1'b1;
                o_freeIdx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/assoc_store.sv
// ---------------------------------------------------------------------------
// assoc_store
// Fully-associative key/value store with round-robin replacement when full.
// One request per cycle over a valid/ready channel; each accepted request
// produces exactly one response held in a one-deep response register.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_op                0 READ, 1 WRITE, 2 DELETE, 3 CLEAR
//   i_req_addr, i_req_wdata key and write data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata             entry data before the op, or MISS_DATA
//   o_rsp_hit               key was present before the op
//   o_rsp_evict             a WRITE displaced a valid entry
//   o_count, o_full         registered occupancy
// ---------------------------------------------------------------------------
module assoc_store
    import assoc_store_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] MISS_DATA = '0,
    localparam int               CNT_W     = countWidth(DEPTH),
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_hit,
    output logic              o_rsp_evict,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full
);

    // Entry storage and bookkeeping
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_key  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [IDX_W-1:0]  r_rrPtr;
    logic [CNT_W-1:0]  r_count;

    // Response register and its FSM
    state_e r_state;
    state_e w_stateNext;
    rsp_t   r_rsp;
    rsp_t   w_rsp;

    // Lookup results and decoded controls
    logic [DEPTH*ADDR_W-1:0] w_keysFlat;
    logic                    w_hit;
    logic [IDX_W-1:0]        w_hitIdx;
    logic                    w_free;
    logic [IDX_W-1:0]        w_freeIdx;
    op_e                     w_op;
    logic                    w_reqReady;
    logic                    w_accept;
    logic                    w_doWrite;
    logic                    w_alloc;
    logic                    w_evict;
    logic                    w_delete;
    logic                    w_clear;
    logic [IDX_W-1:0]        w_wrIdx;
    logic [IDX_W-1:0]        w_rrNext;

    // The lookup block wants the keys as one flat vector
    always_comb begin
        w_keysFlat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_keysFlat[i*ADDR_W +: ADDR_W] = r_key[i];
        end
    end

    assoc_store_find #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_find (
        .i_valid   (r_valid),
        .i_keys    (w_keysFlat),
        .i_addr    (i_req_addr),
        .o_hit     (w_hit),
        .o_hitIdx  (w_hitIdx),
        .o_free    (w_free),
        .o_freeIdx (w_freeIdx)
    );

    // Handshake and operation decode. A full store is exactly the case with
    // no free slot, so the free flag alone selects allocate versus evict.
    // The write target is the matching entry, else the lowest free entry,
    // else the round-robin victim.
    always_comb begin
        w_op       = op_e'(i_req_op);
        w_reqReady = !i_rst && ((r_state == ST_IDLE) || i_rsp_ready);
        w_accept   = i_req_valid && w_reqReady;
        w_doWrite  = w_accept && (w_op == OP_WRITE);
        w_alloc    = w_doWrite && !w_hit && w_free;
        w_evict    = w_doWrite && !w_hit && !w_free;
        w_delete   = w_accept && (w_op == OP_DELETE) && w_hit;
        w_clear    = w_accept && (w_op == OP_CLEAR);
        w_wrIdx    = w_hit ? w_hitIdx : (w_free ? w_freeIdx : r_rrPtr);
        w_rrNext   = (r_rrPtr == IDX_W'(DEPTH - 1)) ? '0 : r_rrPtr + IDX_W'(1);
    end

    // Response contents are computed from the state as it stands before
    // the op, so hit/rdata always describe the entry prior to any change.
    always_comb begin
        w_rsp       = '0;
        w_rsp.rdata = PKG_DATA_W'(MISS_DATA);
        unique case (w_op)
            OP_READ, OP_DELETE: begin
                if (w_hit) begin
                    w_rsp.hit   = 1'b1;
                    w_rsp.rdata = PKG_DATA_W'(r_data[w_hitIdx]);
                end
            end
            OP_WRITE: begin
                if (w_hit) begin
                    w_rsp.hit   = 1'b1;
                    w_rsp.rdata = PKG_DATA_W'(r_data[w_hitIdx]);
                end else if (!w_free) begin
                    w_rsp.evict = 1'b1;
                    w_rsp.rdata = PKG_DATA_W'(r_data[r_rrPtr]);
                end
            end
            OP_CLEAR: begin
                w_rsp.rdata = PKG_DATA_W'(MISS_DATA);
            end
            default: begin
                w_rsp.rdata = PKG_DATA_W'(MISS_DATA);
            end
        endcase
    end

    // Valid bits, occupancy and replacement pointer. Allocation and delete
    // are mutually exclusive (different opcodes), so count moves by at most
    // one per cycle and can neither exceed DEPTH nor underflow: allocation
    // requires a free slot and delete requires a hit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_count <= '0;
            r_rrPtr <= '0;
        end else if (w_clear) begin
            r_valid <= '0;
            r_count <= '0;
            r_rrPtr <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[w_wrIdx] <= 1'b1;
                r_count          <= r_count + CNT_W'(1);
            end
            if (w_evict) begin
                r_rrPtr <= w_rrNext;
            end
            if (w_delete) begin
                r_valid[w_hitIdx] <= 1'b0;
                r_count           <= r_count - CNT_W'(1);
            end
        end
    end

    // Key/data payload. It is never observed without its valid bit, so it
    // needs no reset. A hitting write keeps its key and only updates data.
    always_ff @(posedge i_clk) begin
        if (w_doWrite) begin
            r_data[w_wrIdx] <= i_req_wdata;
            if (!w_hit) begin
                r_key[w_wrIdx] <= i_req_addr;
            end
        end
    end

    // Response FSM state register; reset discards any pending response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: a new accept always refills the register (this covers the
    // back-to-back case); otherwise a consumed response empties it and an
    // unconsumed one is held.
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_accept) begin
                    w_stateNext = ST_RESP;
                end else if (i_rsp_ready) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Response payload only loads on accept, keeping it stable under stall
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp <= '0;
        end else if (w_accept) begin
            r_rsp <= w_rsp;
        end
    end

    assign o_req_ready = w_reqReady;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_rdata = DATA_W'(r_rsp.rdata);
    assign o_rsp_hit   = r_rsp.hit;
    assign o_rsp_evict = r_rsp.evict;
    assign o_count     = r_count;
    assign o_full      = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_assoc_store.sv
// ---------------------------------------------------------------------------
// tb_assoc_store
// Scoreboard bench for assoc_store (DEPTH=4, 64-bit keys and data).
// The driver pushes the reference model's expected response when a request
// is accepted; an independent monitor pops and compares whenever a response
// is consumed. Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_assoc_store;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] rdata;
        logic        hit;
        logic        evict;
        int          cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_hit;
    logic        rsp_evict;
    logic [2:0]  count;
    logic        full;

    int total = 0;
    int bad   = 0;
    int readyMode = 0;

    exp_t expQ[$];

    // Reference model: DEPTH slots plus a replacement pointer
    logic        mValid [DEPTH];
    logic [63:0] mKey   [DEPTH];
    logic [63:0] mData  [DEPTH];
    int          mRr;

    // Most recently consumed response, for directed spot checks
    logic [63:0] lastRdata;
    logic        lastHit;
    logic        lastEvict;
    int          lastCount;

    assoc_store #(
        .DATA_W    (64),
        .ADDR_W    (64),
        .DEPTH     (DEPTH),
        .MISS_DATA (64'h0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_hit   (rsp_hit),
        .o_rsp_evict (rsp_evict),
        .o_count     (count),
        .o_full      (full)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: always ready, random, or stalled, changed just after
    // each rising edge so it is stable through the following edge
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // Hard stop in case something wedges beyond every bounded wait
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        mRr = 0;
    endfunction

    // Apply one operation to the model and return what the store must answer
    function automatic exp_t modelOp(input logic [1:0] op, input logic [63:0] a,
                                     input logic [63:0] d);
        exp_t e;
        int   idx     = -1;
        int   freeIdx = -1;
        e.rdata = 64'h0;
        e.hit   = 1'b0;
        e.evict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (mValid[i] && mKey[i] == a) idx = i;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!mValid[i]) freeIdx = i;
        case (op)
            2'd0: if (idx >= 0) begin
                e.hit = 1'b1; e.rdata = mData[idx];
            end
            2'd1: begin
                if (idx >= 0) begin
                    e.hit = 1'b1; e.rdata = mData[idx]; mData[idx] = d;
                end else if (freeIdx >= 0) begin
                    mValid[freeIdx] = 1'b1; mKey[freeIdx] = a; mData[freeIdx] = d;
                end else begin
                    e.evict = 1'b1; e.rdata = mData[mRr];
                    mKey[mRr] = a; mData[mRr] = d;
                    mRr = (mRr + 1) % DEPTH;
                end
            end
            2'd2: if (idx >= 0) begin
                e.hit = 1'b1; e.rdata = mData[idx]; mValid[idx] = 1'b0;
            end
            default: modelReset();
        endcase
        e.cnt = 0;
        for (int i = 0; i < DEPTH; i++) if (mValid[i]) e.cnt++;
        return e;
    endfunction

    // Drive one request and hold it until accepted; the expected response
    // is queued when acceptance is certain at the coming edge
    task automatic applyStimulus(input logic [1:0] op, input logic [63:0] addr,
                                 input logic [63:0] data);
        int waited = 0;
        bit done   = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                expQ.push_back(modelOp(op, addr, data));
                done = 1;
            end else if (++waited > 200) begin
                checkOutput("accept timeout", 64'(waited), 64'd0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic setReadyMode(input int m);
        readyMode = m;
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) until every queued response has been consumed
    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0)
            checkOutput("drain timeout", 64'(expQ.size()), 64'd0);
        #2;
    endtask

    // Monitor: compare every consumed response against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious response", 64'(expQ.size()), 64'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp rdata", rsp_rdata, e.rdata);
                checkOutput("rsp hit", 64'(rsp_hit), 64'(e.hit));
                checkOutput("rsp evict", 64'(rsp_evict), 64'(e.evict));
                checkOutput("rsp count", 64'(count), 64'(e.cnt));
                checkOutput("rsp full", 64'(full), 64'(e.cnt == DEPTH));
                lastRdata = rsp_rdata;
                lastHit   = rsp_hit;
                lastEvict = rsp_evict;
                lastCount = int'(count);
            end
        end
    end

    initial begin
        logic [63:0] key;
        int          r;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("por req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-stream: a stalled response is discarded
        setReadyMode(2);
        applyStimulus(2'd1, 64'h10, 64'h55);
        #1;
        checkOutput("t1 pending valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        expQ.delete();
        modelReset();
        checkOutput("t1 rst rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("t1 rst rdata", rsp_rdata, 64'd0);
        checkOutput("t1 rst hit", 64'(rsp_hit), 64'd0);
        checkOutput("t1 rst evict", 64'(rsp_evict), 64'd0);
        checkOutput("t1 rst count", 64'(count), 64'd0);
        checkOutput("t1 rst full", 64'(full), 64'd0);
        checkOutput("t1 rst req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t1 req_ready after release", 64'(req_ready), 64'd1);
        setReadyMode(0);
        applyStimulus(2'd0, 64'h10, 64'h0);
        waitDrain();
        checkOutput("t1 read hit", 64'(lastHit), 64'd0);
        checkOutput("t1 read rdata", lastRdata, 64'd0);

        // Write then read back-to-back
        applyStimulus(2'd1, 64'h10, 64'hAA);
        applyStimulus(2'd0, 64'h10, 64'h0);
        waitDrain();
        checkOutput("t2 read hit", 64'(lastHit), 64'd1);
        checkOutput("t2 read rdata", lastRdata, 64'hAA);
        checkOutput("t2 count", 64'(lastCount), 64'd1);

        // Overwrite in place
        applyStimulus(2'd1, 64'h10, 64'hBB);
        waitDrain();
        checkOutput("t3 hit", 64'(lastHit), 64'd1);
        checkOutput("t3 old data", lastRdata, 64'hAA);
        checkOutput("t3 count", 64'(lastCount), 64'd1);

        // Fill from empty and evict round-robin
        applyStimulus(2'd3, 64'h0, 64'h0);
        for (int k = 1; k <= 4; k++) applyStimulus(2'd1, 64'(k), 64'h100 + 64'(k));
        waitDrain();
        checkOutput("t4 full", 64'(full), 64'd1);
        applyStimulus(2'd1, 64'd5, 64'h105);
        waitDrain();
        checkOutput("t4 evict5", 64'(lastEvict), 64'd1);
        checkOutput("t4 evict5 data", lastRdata, 64'h101);
        applyStimulus(2'd1, 64'd6, 64'h106);
        waitDrain();
        checkOutput("t4 evict6", 64'(lastEvict), 64'd1);
        checkOutput("t4 evict6 data", lastRdata, 64'h102);
        applyStimulus(2'd0, 64'd1, 64'h0);
        waitDrain();
        checkOutput("t4 read1 miss", 64'(lastHit), 64'd0);

        // Delete and slot reuse
        applyStimulus(2'd2, 64'd3, 64'h0);
        waitDrain();
        checkOutput("t5 del hit", 64'(lastHit), 64'd1);
        checkOutput("t5 del count", 64'(lastCount), 64'd3);
        applyStimulus(2'd2, 64'd3, 64'h0);
        waitDrain();
        checkOutput("t5 del again", 64'(lastHit), 64'd0);
        applyStimulus(2'd1, 64'd7, 64'h107);
        waitDrain();
        checkOutput("t5 reuse evict", 64'(lastEvict), 64'd0);
        checkOutput("t5 reuse count", 64'(lastCount), 64'd4);

        // Backpressure: held response stays put and nothing is accepted
        setReadyMode(2);
        applyStimulus(2'd0, 64'd7, 64'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t6 stall valid", 64'(rsp_valid), 64'd1);
            checkOutput("t6 stall rdata", rsp_rdata, 64'h107);
            checkOutput("t6 stall hit", 64'(rsp_hit), 64'd1);
            checkOutput("t6 stall req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        setReadyMode(0);
        waitDrain();
        applyStimulus(2'd3, 64'h0, 64'h0);
        waitDrain();
        checkOutput("t6 clear count", 64'(count), 64'd0);
        checkOutput("t6 clear full", 64'(full), 64'd0);
        for (int k = 4; k <= 7; k++) begin
            applyStimulus(2'd0, 64'(k), 64'h0);
            waitDrain();
            checkOutput("t6 read after clear", 64'(lastHit), 64'd0);
        end

        // Randomized traffic with random consumer backpressure; keys that
        // differ only in bit 63 must be distinct
        setReadyMode(1);
        for (int n = 0; n < 400; n++) begin
            key = 64'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) key[63] = 1'b1;
            r = int'($urandom_range(0, 99));
            if (r < 35)      applyStimulus(2'd0, key, 64'h0);
            else if (r < 75) applyStimulus(2'd1, key, {$urandom, $urandom});
            else if (r < 95) applyStimulus(2'd2, key, 64'h0);
            else             applyStimulus(2'd3, key, 64'h0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        setReadyMode(0);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/assoc_store.md
# assoc_store

Parametrised, synthesizable fully-associative key/value store: the hardware successor to the testbench associative-array memory model. It accepts read, write, delete and clear requests over a valid/ready channel and answers each with one response carrying a hit flag. When full, it replaces entries round-robin. It sits between a traffic generator (or bus adapter) and any consumer needing a small sparse address map.

## Interface
- `DATA_W`, 64: data width.
- `ADDR_W`, 64: key/address width.
- `DEPTH`, 16: number of entries, ≥2.
- `MISS_DATA`, '0: `rsp_rdata` value on read/delete miss.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_op` in 2: 0 READ, 1 WRITE, 2 DELETE, 3 CLEAR.
- `req_addr` in ADDR_W: key.
- `req_wdata` in DATA_W: write data, used only for WRITE.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out DATA_W: response data.
- `rsp_hit` out 1: key was present before the operation.
- `rsp_evict` out 1: a WRITE displaced a valid entry.
- `count` out $clog2(DEPTH+1): number of valid entries.
- `full` out 1: `count == DEPTH`.

## Operation
- **Storage:** per entry, `valid`, `key[ADDR_W]` and `data[DATA_W]`. Keys are unique by construction.
- **Lookup:** a combinational compare of `req_addr` against all valid keys.
- **READ:**
  - Hit: `rdata` = entry data, `hit` = 1.
  - Miss: `rdata` = MISS_DATA, `hit` = 0.
  - State is unchanged.
- **WRITE hit:** overwrite data in place. `hit` = 1, `evict` = 0, `rdata` = old data.
- **WRITE miss, not full:** allocate the lowest-index invalid entry. `hit` = 0, `evict` = 0, `rdata` = MISS_DATA, `count` +1.
- **WRITE miss, full:**
  - Replace the entry at `rr_ptr`. `evict` = 1, `rdata` = evicted data.
  - `rr_ptr` advances by 1 and wraps from DEPTH-1 to 0. `count` is unchanged.
- **DELETE:**
  - Hit: clear `valid`, `rdata` = old data, `hit` = 1, `count` -1.
  - Miss: `rdata` = MISS_DATA, `hit` = 0.
- **CLEAR:**
  - All `valid` bits go to 0, `count` = 0, `rr_ptr` = 0.
  - Response has `hit` = 0, `evict` = 0, `rdata` = MISS_DATA.
- `rr_ptr` changes only on an eviction or a CLEAR.
- **Response register:** one deep. State machine has two states:
  - `IDLE` (`rsp_valid` = 0) goes to `RESP` on accept.
  - `RESP` goes to `IDLE` on `rsp_ready && !req_valid`.
  - `RESP` stays in `RESP` on `rsp_ready && req_valid` (back-to-back).
  - `RESP` holds while `!rsp_ready`.
- `req_ready` = `!rst && (!rsp_valid || rsp_ready)`.

## Timing
- **Reset (async assert):**
  - All `valid` = 0, `rr_ptr` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_hit` = 0, `rsp_evict` = 0.
  - `count` = 0, `full` = 0, `req_ready` = 0.
- A reset during a pending response discards that response.
- **Latency:**
  - A request accepted at edge N updates state and presents its response after edge N.
  - Throughput is 1 op/cycle while `rsp_ready` is held 1.
- **Ordering:** a request accepted at edge N+1 observes state written at edge N. READ-after-WRITE to the same key returns the new data with no bubble.
- **Backpressure:** while `rsp_valid && !rsp_ready`, all `rsp_*` outputs are stable and no request is accepted.
- `count`/`full` are registered and reflect all operations accepted up to the previous edge.
- **Width rules:**
  - Keys compare on all ADDR_W bits.
  - `count` never exceeds DEPTH and never underflows. A DELETE miss at `count` = 0 leaves it at 0.

## Structure
- Package `assoc_store_pkg` holds:
  - the `op_e` enum (READ/WRITE/DELETE/CLEAR);
  - the response struct (`rdata`, `hit`, `evict`);
  - a `clog2`-based count-width helper.
- Sub-module `assoc_store_find`: parametrised priority encoder over DEPTH. It outputs the hit index with a hit flag, and the first-free index with a free flag.
- Top level holds the entry arrays, `rr_ptr`, `count`, and the response register/FSM.

## Test plan
All scenarios use DEPTH=4, ADDR_W=64, DATA_W=64, MISS_DATA=0.

1. **Reset mid-stream:** assert `rst` while `rsp_valid` = 1, then release → all outputs 0, `req_ready` returns 1 the cycle after release, and READ 0x10 → `hit` = 0, `rdata` = 0.
2. **Write then read:** WRITE 0x10←0xAA, then READ 0x10 back-to-back → second response `hit` = 1, `rdata` = 0xAA, `count` = 1.
3. **Overwrite:** WRITE 0x10←0xBB over the existing entry → `hit` = 1, `rdata` = 0xAA, `count` stays 1.
4. **Fill and evict:**
   - WRITE keys 1,2,3,4 → `full` = 1.
   - WRITE key 5 → `evict` = 1, `rdata` = data of key 1.
   - WRITE key 6 → evicts key 2 (`rr_ptr` advances).
   - READ 1 → miss.
5. **Delete and reuse:**
   - DELETE 3 → `hit` = 1, `count` = 3.
   - DELETE 3 again → `hit` = 0.
   - WRITE 7 reuses the freed slot, `evict` = 0.
6. **Backpressure and clear:**
   - Hold `rsp_ready` = 0 for 5 cycles → response stable, `req_ready` = 0.
   - Then CLEAR → `count` = 0, `full` = 0, and every subsequent READ misses.
